// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: shares one memory slave port between instruction fetch (IFU) and load/store (LSU).
// Build macro MEM_ARB_RR_EN selects round-robin arbitration; default is fixed LSU priority.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  // instruction fetch master
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_resp_valid,
  output logic [DW-1:0] ifu_rdata,
  // load/store master
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic          lsu_we,
  input  logic [1:0]    lsu_format,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  output logic          lsu_resp_valid,
  output logic [DW-1:0] lsu_rdata,
  // memory slave
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_we,
  output logic [1:0]    mem_format,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  localparam logic [7:0] C_TIMEOUT  = 8'(TIMEOUT);
  localparam logic [1:0] C_FMT_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner;   // 1 = LSU owns the transaction in flight
  logic [7:0]    r_cnt;
  logic          r_we;
  logic [1:0]    r_fmt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_err;

  logic w_grant_ifu;
  logic w_grant_lsu;
  logic w_resp_hit;
  logic w_timeout;
  logic w_abort;

`ifdef MEM_ARB_RR_EN
  logic r_last;   // 1 = LSU received the most recent grant

  always_comb begin
    w_grant_ifu = 1'b0;
    w_grant_lsu = 1'b0;
    if (r_state == S_IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        w_grant_ifu = r_last;
        w_grant_lsu = ~r_last;
      end else begin
        w_grant_ifu = ifu_req_valid;
        w_grant_lsu = lsu_req_valid;
      end
    end
  end
`else
  always_comb begin
    w_grant_ifu = 1'b0;
    w_grant_lsu = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant_lsu = lsu_req_valid;
      w_grant_ifu = ifu_req_valid & ~lsu_req_valid;
    end
  end
`endif

  // A real response in the same cycle as the timeout wins; the abort only fires without one.
  assign w_resp_hit = (r_state == S_WAIT) && mem_resp_valid;
  assign w_timeout  = (r_state != S_IDLE) && (r_cnt == C_TIMEOUT);
  assign w_abort    = w_timeout && !w_resp_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_cnt   <= 8'd0;
      r_we    <= 1'b0;
      r_fmt   <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last  <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_ifu || w_grant_lsu) begin
            r_state <= S_ISSUE;
            r_owner <= w_grant_lsu;
            r_cnt   <= 8'd0;
            r_we    <= w_grant_lsu ? lsu_we : 1'b0;
            r_fmt   <= w_grant_lsu ? lsu_format : C_FMT_WORD;
            r_addr  <= w_grant_lsu ? lsu_addr : ifu_addr;
            r_wdata <= w_grant_lsu ? lsu_wdata : '0;
`ifdef MEM_ARB_RR_EN
            r_last  <= w_grant_lsu;
`endif
          end
        end
        S_ISSUE: begin
          if (w_timeout) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (mem_req_ready) begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ifu_req_ready  = w_grant_ifu;
  assign lsu_req_ready  = w_grant_lsu;

  assign ifu_resp_valid = (w_resp_hit || w_abort) && !r_owner;
  assign lsu_resp_valid = (w_resp_hit || w_abort) &&  r_owner;
  assign ifu_rdata      = (w_resp_hit && !r_owner) ? mem_rdata : '0;
  assign lsu_rdata      = (w_resp_hit &&  r_owner) ? mem_rdata : '0;

  assign mem_req_valid  = (r_state == S_ISSUE);
  assign mem_we         = r_we;
  assign mem_format     = r_fmt;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign bus_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: transaction-level model of the arbiter plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid;
  logic [1:0]    lsu_format;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic          mem_req_valid, mem_req_ready, mem_we, mem_resp_valid, bus_err;
  logic [1:0]    mem_format;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_format(lsu_format), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_format(mem_format), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: one transaction in flight, its age in cycles since acceptance, and whether the slave took it.
  bit            m_busy, m_lsu, m_acc, m_last, m_err, m_we;
  logic [1:0]    m_fmt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_age;
  bit            e_gi, e_gl, e_dlv, e_to;
  bit            grants[$];

  // Slave responder and master hold behaviour.
  int            s_ready_lat = 0, s_resp_lat = 1, s_cnt = 0, s_iss = 0;
  bit            s_silent = 0;
  logic [DW-1:0] s_rdata = '0;
  bit            hs_seen, ifu_acc, lsu_acc, ifu_hold = 0, lsu_hold = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_lsu = 0; m_acc = 0; m_last = 1; m_err = 0; m_we = 0;
    m_fmt = '0; m_addr = '0; m_wdata = '0; m_age = 0;
  endtask

  // Falling edge: derive the required outputs from the model and the current inputs, then compare.
  task automatic t_neg();
    logic [DW-1:0] e_ird, e_lrd;
    @(negedge clk);
    hs_seen = mem_req_valid && mem_req_ready;
    ifu_acc = ifu_req_valid && ifu_req_ready;
    lsu_acc = lsu_req_valid && lsu_req_ready;
    e_gi = 0; e_gl = 0; e_dlv = 0; e_to = 0;
    if (!rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (ifu_req_valid && lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
        if (m_last) e_gi = 1; else e_gl = 1;
`else
        e_gl = 1;
`endif
      end else begin
        e_gi = ifu_req_valid;
        e_gl = lsu_req_valid;
      end
    end else begin
      e_dlv = m_acc && mem_resp_valid;
      e_to  = !e_dlv && (m_age == TMO + 1);
    end
    e_ird = (e_dlv && !m_lsu) ? mem_rdata : '0;
    e_lrd = (e_dlv &&  m_lsu) ? mem_rdata : '0;
    chk("ifu_req_ready", ifu_req_ready, e_gi);
    chk("lsu_req_ready", lsu_req_ready, e_gl);
    chk("mem_req_valid", mem_req_valid, m_busy && !m_acc);
    chk("ifu_resp_valid", ifu_resp_valid, (e_dlv || e_to) && !m_lsu);
    chk("lsu_resp_valid", lsu_resp_valid, (e_dlv || e_to) && m_lsu);
    chk("ifu_rdata", ifu_rdata, e_ird);
    chk("lsu_rdata", lsu_rdata, e_lrd);
    chk("mem_we", mem_we, m_we);
    chk("mem_format", mem_format, m_fmt);
    chk("mem_addr", mem_addr, m_addr);
    if (m_lsu) chk("mem_wdata", mem_wdata, m_wdata);
    chk("bus_err", bus_err, m_err);
  endtask

  // Rising edge: advance the model, then drive the masters and the slave for the next cycle.
  task automatic t_pos();
    @(posedge clk);
    cyc++;
    if (!rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (e_gi || e_gl) begin
        m_busy = 1; m_lsu = e_gl; m_acc = 0; m_age = 1; m_last = e_gl;
        grants.push_back(e_gl);
        m_we   = e_gl ? lsu_we : 1'b0;
        m_fmt  = e_gl ? lsu_format : 2'b10;
        m_addr = e_gl ? lsu_addr : ifu_addr;
        if (e_gl) m_wdata = lsu_wdata;
      end
    end else if (e_dlv || e_to) begin
      m_busy = 0;
      if (e_to) m_err = 1;
    end else begin
      m_age++;
      if (!m_acc && mem_req_ready) m_acc = 1;
    end
    #1;
    if (ifu_acc && !ifu_hold) ifu_req_valid = 0;
    if (lsu_acc && !lsu_hold) lsu_req_valid = 0;
    mem_resp_valid = 0;
    mem_rdata = 32'hBAD0_0000 | 32'(cyc);
    if (hs_seen) s_cnt = s_resp_lat;
    if (s_cnt > 0) begin
      s_cnt--;
      if (s_cnt == 0 && !s_silent) begin
        mem_resp_valid = 1;
        mem_rdata = s_rdata;
      end
    end
    if (mem_req_valid) begin
      s_iss++;
      mem_req_ready = (s_iss > s_ready_lat);
    end else begin
      s_iss = 0;
      mem_req_ready = 0;
    end
  endtask

  task automatic cycle();
    t_neg();
    t_pos();
  endtask

  int n_iss, n_resp, c0, c_to;
  bit got;
  bit exp_g[4];

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
    exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 1;
`endif
    rst = 0;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_we = 0; lsu_format = '0; lsu_addr = '0; lsu_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    model_reset();
    repeat (3) cycle();
    t_neg();
    chk("reset_bus_err", bus_err, 0);
    chk("reset_mem_valid", mem_req_valid, 0);
    chk("reset_mem_addr", mem_addr, 0);
    t_pos();
    rst = 1;
    cycle();

    // Single fetch with an immediate slave.
    s_ready_lat = 0; s_resp_lat = 1; s_rdata = 32'h0000_0413;
    ifu_addr = 32'h8000_0000; ifu_req_valid = 1;
    t_neg(); chk("t1_ifu_ready_c0", ifu_req_ready, 1); t_pos();
    t_neg(); chk("t1_mem_valid_c1", mem_req_valid, 1); chk("t1_mem_addr_c1", mem_addr, 32'h8000_0000); t_pos();
    t_neg();
    chk("t1_ifu_resp_c2", ifu_resp_valid, 1);
    chk("t1_ifu_rdata_c2", ifu_rdata, 32'h0000_0413);
    chk("t1_lsu_resp_c2", lsu_resp_valid, 0);
    t_pos();
    repeat (2) cycle();

    // Store with a slave that stalls ready for three cycles.
    s_ready_lat = 3; s_resp_lat = 2; s_rdata = 32'h1234_5678;
    lsu_we = 1; lsu_format = 2'b10; lsu_addr = 32'h8000_0100; lsu_wdata = 32'hDEAD_BEEF; lsu_req_valid = 1;
    n_iss = 0; n_resp = 0;
    for (int i = 0; i < 14; i++) begin
      t_neg();
      if (mem_req_valid) begin
        n_iss++;
        chk("t2_mem_addr", mem_addr, 32'h8000_0100);
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      end
      if (lsu_resp_valid) n_resp++;
      t_pos();
    end
    chk("t2_issue_cycles", n_iss, 4);
    chk("t2_resp_pulses", n_resp, 1);

    // Both masters requesting continuously.
    s_ready_lat = 0; s_resp_lat = 1; s_rdata = 32'h0BAD_F00D;
    grants.delete();
    ifu_hold = 1; lsu_hold = 1;
    ifu_addr = 32'h8000_0040; lsu_we = 0; lsu_format = 2'b01; lsu_addr = 32'h8000_0200;
    ifu_req_valid = 1; lsu_req_valid = 1;
    for (int i = 0; i < 40 && grants.size() < 4; i++) cycle();
    ifu_req_valid = 0; lsu_req_valid = 0; ifu_hold = 0; lsu_hold = 0;
    repeat (6) cycle();
    chk("t3_grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      if (grants.size() > i) chk($sformatf("t3_grant%0d_is_lsu", i), grants[i], exp_g[i]);

    // Slave never responds: abort after the timeout.
    s_silent = 1; s_ready_lat = 0; s_resp_lat = 1;
    ifu_addr = 32'h8000_0080; ifu_req_valid = 1;
    c0 = -100; c_to = -1;
    for (int i = 0; i < 30 && c_to < 0; i++) begin
      t_neg();
      if (ifu_req_ready) c0 = cyc;
      if (ifu_resp_valid) begin
        c_to = cyc;
        chk("t4_abort_rdata", ifu_rdata, 0);
      end
      t_pos();
    end
    chk("t4_abort_offset", c_to - c0, TMO + 1);
    s_silent = 0;
    t_neg(); chk("t4_bus_err_set", bus_err, 1); t_pos();
    s_rdata = 32'hCAFE_0001; lsu_we = 0; lsu_format = 2'b10; lsu_addr = 32'h8000_0300; lsu_req_valid = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      t_neg();
      if (lsu_resp_valid) begin
        got = 1;
        chk("t4_next_rdata", lsu_rdata, 32'hCAFE_0001);
      end
      t_pos();
    end
    chk("t4_next_served", got, 1);
    t_neg(); chk("t4_bus_err_sticky", bus_err, 1); t_pos();
    repeat (2) cycle();

    // Reset while waiting; the slave answers one cycle after release.
    s_resp_lat = 4; s_rdata = 32'h5555_AAAA;
    ifu_addr = 32'h8000_0400; ifu_req_valid = 1;
    t_neg(); chk("t5_accept", ifu_req_ready, 1); t_pos();
    cycle();
    cycle();
    rst = 0;
    t_neg();
    chk("t5_rst_mem_valid", mem_req_valid, 0);
    chk("t5_rst_ifu_resp", ifu_resp_valid, 0);
    chk("t5_rst_bus_err", bus_err, 0);
    chk("t5_rst_mem_addr", mem_addr, 0);
    t_pos();
    rst = 1;
    n_resp = 0;
    for (int i = 0; i < 6; i++) begin
      t_neg();
      if (ifu_resp_valid || lsu_resp_valid) n_resp++;
      t_pos();
    end
    chk("t5_no_resp_after_reset", n_resp, 0);
    s_resp_lat = 1; s_rdata = 32'h0000_0513; ifu_addr = 32'h8000_0004; ifu_req_valid = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      t_neg();
      if (ifu_resp_valid) begin
        got = 1;
        chk("t5_next_rdata", ifu_rdata, 32'h0000_0513);
      end
      t_pos();
    end
    chk("t5_next_served", got, 1);
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
